// File: rtl/toy_bus_ack_rr_arb.sv
// Round-robin arbiter that merges four ToyBusAck requesters into one registered output.
// Latency: 1 cycle from input handshake to out0_vld; sustains 1 beat/cycle while out0_rdy=1.
// Backpressure: out0_rdy=0 with a held beat freezes the output and rr_ptr; all inK_rdy go low.
// Optional grant counters (cnt_clr, grant_cnt0..3) are built when TOY_BUS_ACK_ARB_STAT_EN is defined.
module toy_bus_ack_rr_arb #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic              in0_opcode,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic              in1_opcode,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [ID_W-1:0]   in1_src_id,
  input  logic [ID_W-1:0]   in1_tgt_id,
  input  logic              in2_vld,
  output logic              in2_rdy,
  input  logic              in2_opcode,
  input  logic [DATA_W-1:0] in2_data,
  input  logic [ID_W-1:0]   in2_src_id,
  input  logic [ID_W-1:0]   in2_tgt_id,
  input  logic              in3_vld,
  output logic              in3_rdy,
  input  logic              in3_opcode,
  input  logic [DATA_W-1:0] in3_data,
  input  logic [ID_W-1:0]   in3_src_id,
  input  logic [ID_W-1:0]   in3_tgt_id,
  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic              out0_opcode,
  output logic [DATA_W-1:0] out0_data,
  output logic [ID_W-1:0]   out0_src_id,
  output logic [ID_W-1:0]   out0_tgt_id
`ifdef TOY_BUS_ACK_ARB_STAT_EN
  ,
  input  logic              cnt_clr,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1,
  output logic [7:0]        grant_cnt2,
  output logic [7:0]        grant_cnt3
`endif
);

  // Payload is carried opaquely; opcode and tgt_id are never decoded here.
  typedef struct packed {
    logic              opcode;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
  } hdr_t;

  hdr_t       in_hdr [4];
  hdr_t       out_q;
  hdr_t       win_hdr;
  logic [3:0] vld_vec;
  logic [3:0] rdy_vec;
  logic [1:0] rr_ptr;
  logic [1:0] win;
  logic [1:0] idx;
  logic       win_vld;
  logic       can_load;
  logic       hs;

  assign vld_vec   = {in3_vld, in2_vld, in1_vld, in0_vld};
  assign in_hdr[0] = {in0_opcode, in0_data, in0_src_id, in0_tgt_id};
  assign in_hdr[1] = {in1_opcode, in1_data, in1_src_id, in1_tgt_id};
  assign in_hdr[2] = {in2_opcode, in2_data, in2_src_id, in2_tgt_id};
  assign in_hdr[3] = {in3_opcode, in3_data, in3_src_id, in3_tgt_id};

  // Pick the first valid requester starting at rr_ptr; scanning offsets high-to-low
  // lets the smallest offset overwrite the others and so take priority.
  always_comb begin
    win     = rr_ptr;
    win_vld = 1'b0;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (vld_vec[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // The output slot can take a new beat when empty or draining this cycle.
  // Reset gates the handshake so no requester sees rdy while rst is high.
  assign can_load = ~out0_vld | out0_rdy;
  assign hs       = can_load & win_vld & ~rst;
  assign rdy_vec  = hs ? (4'b0001 << win) : 4'b0000;
  assign win_hdr  = in_hdr[win];

  assign in0_rdy = rdy_vec[0];
  assign in1_rdy = rdy_vec[1];
  assign in2_rdy = rdy_vec[2];
  assign in3_rdy = rdy_vec[3];

  assign out0_opcode = out_q.opcode;
  assign out0_data   = out_q.data;
  assign out0_src_id = out_q.src_id;
  assign out0_tgt_id = out_q.tgt_id;

  // Output register and round-robin pointer; the pointer only moves on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_vld <= 1'b0;
      out_q    <= '0;
      rr_ptr   <= 2'd0;
    end else if (hs) begin
      out0_vld <= 1'b1;
      out_q    <= win_hdr;
      rr_ptr   <= win + 2'd1;
    end else if (out0_vld && out0_rdy) begin
      out0_vld <= 1'b0;
    end
  end

`ifdef TOY_BUS_ACK_ARB_STAT_EN
  logic [7:0] grant_cnt [4];

  // Saturating per-requester grant counters; clear wins over a same-cycle grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) grant_cnt[k] <= 8'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cnt_clr)
          grant_cnt[k] <= 8'd0;
        else if (rdy_vec[k] && grant_cnt[k] != 8'hFF)
          grant_cnt[k] <= grant_cnt[k] + 8'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt[0];
  assign grant_cnt1 = grant_cnt[1];
  assign grant_cnt2 = grant_cnt[2];
  assign grant_cnt3 = grant_cnt[3];
`endif

endmodule
